// File: rtl/noc_link_pipe_pkg.sv
// Shared types and constants for the registered NoC link pipeline.
// Both the link top and its skid stages import this package.
package noc_link_pipe_pkg;

  localparam int NOC_LINK_STAGES_MAX = 4;
  localparam int NOC_FLIT_W          = 64;
  localparam int NOC_VC_NUM          = 2;
  localparam int NOC_NODES           = 16;

  typedef logic [NOC_FLIT_W-1:0] noc_flit_t;
  typedef logic [NOC_VC_NUM-1:0] noc_vc_mask_t;

  // Link depth for each fabric node. This replaces the old one-bit link-register option.
  localparam int NOC_LINK_DEPTH [NOC_NODES] = '{default: 2};

  // The encoding equals the number of flits the stage holds.
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_HALF  = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

  function automatic int occ_width(input int stages);
    return (stages == 0) ? 1 : $clog2(2 * stages + 1);
  endfunction

endpackage

// File: rtl/noc_link_pipe_skid_stage.sv
// One full-throughput, two-entry skid stage.
// Both the forward data path and ready_out are fully registered.
module noc_skid_stage
  import noc_link_pipe_pkg::*;
#(
  parameter int FLIT_W = NOC_FLIT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [FLIT_W-1:0] in_flit_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [FLIT_W-1:0] out_flit_o,
  output logic [1:0]        count_o
);

  skid_state_e       state_q, state_d;
  logic              ready_q, ready_d;
  logic [FLIT_W-1:0] main_q, main_d;
  logic [FLIT_W-1:0] skid_q, skid_d;
  logic              push, pop;

  assign push = in_valid_i & ready_q;
  assign pop  = (state_q != SKID_EMPTY) & out_ready_i;

  // NOTE: every signal is given a default first, so no path through the case leaves a latch.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      SKID_EMPTY: begin
        if (push) begin
          state_d = SKID_HALF;
          main_d  = in_flit_i;
        end
      end
      SKID_HALF: begin
        if (push && !pop) begin
          state_d = SKID_FULL;
          skid_d  = in_flit_i;
        end else if (push && pop) begin
          main_d = in_flit_i;
        end else if (pop) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_FULL: begin
        if (pop) begin
          state_d = SKID_HALF;
          main_d  = skid_q;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
    ready_d = (state_d != SKID_FULL);
  end

  // NOTE: use non-blocking assignments in clocked blocks, so all registers update together at the edge.
  // NOTE: the flit registers are reset as well, because the downstream flit must read zero during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SKID_EMPTY;
      ready_q <= 1'b0;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign in_ready_o  = ready_q;
  assign out_valid_o = (state_q != SKID_EMPTY);
  assign out_flit_o  = main_q;
  assign count_o     = 2'(state_q);

endmodule

// File: rtl/noc_link_pipe.sv
// Registered one-direction link between two mesh routers.
// It chains skid stages, delays per-VC ready by the same depth, and reports occupancy and a delivered-flit count.
module noc_link_pipe
  import noc_link_pipe_pkg::*;
#(
  parameter int LINK_STAGES = 2,
  parameter int FLIT_W      = NOC_FLIT_W,
  parameter int VC_NUM      = NOC_VC_NUM,
  parameter int CNT_W       = 32
) (
  input  logic                                noc_clk,
  input  logic                                noc_rst_n,
  input  logic                                rx_valid,
  output logic                                rx_ready,
  input  logic [FLIT_W-1:0]                   rx_flit,
  output logic [VC_NUM-1:0]                   rx_vc_ready,
  output logic                                tx_valid,
  input  logic                                tx_ready,
  output logic [FLIT_W-1:0]                   tx_flit,
  input  logic [VC_NUM-1:0]                   tx_vc_ready,
  output logic [occ_width(LINK_STAGES)-1:0]   occupancy,
  output logic [CNT_W-1:0]                    flit_cnt
);

  localparam int OCC_W = occ_width(LINK_STAGES);

  if (LINK_STAGES < 0 || LINK_STAGES > NOC_LINK_STAGES_MAX) begin : g_bad_depth
    $error("noc_link_pipe: LINK_STAGES must be within 0..%0d", NOC_LINK_STAGES_MAX);
  end

  if (LINK_STAGES == 0) begin : g_wire
    assign rx_ready    = tx_ready;
    assign tx_valid    = rx_valid;
    assign tx_flit     = rx_flit;
    assign rx_vc_ready = tx_vc_ready;
    assign occupancy   = '0;
  end else begin : g_pipe
    logic              valid_c [LINK_STAGES+1];
    logic              ready_c [LINK_STAGES+1];
    logic [FLIT_W-1:0] flit_c  [LINK_STAGES+1];
    logic [1:0]        count_c [LINK_STAGES];
    logic [VC_NUM-1:0] vc_q    [LINK_STAGES];
    logic [OCC_W-1:0]  occ_sum;

    assign valid_c[0]           = rx_valid;
    assign flit_c[0]            = rx_flit;
    assign rx_ready             = ready_c[0];
    assign ready_c[LINK_STAGES] = tx_ready;
    assign tx_valid             = valid_c[LINK_STAGES];
    assign tx_flit              = flit_c[LINK_STAGES];

    for (genvar s = 0; s < LINK_STAGES; s++) begin : g_stage
      noc_skid_stage #(
        .FLIT_W (FLIT_W)
      ) u_stage (
        .clk         (noc_clk),
        .rst_n       (noc_rst_n),
        .in_valid_i  (valid_c[s]),
        .in_ready_o  (ready_c[s]),
        .in_flit_i   (flit_c[s]),
        .out_valid_o (valid_c[s+1]),
        .out_ready_i (ready_c[s+1]),
        .out_flit_o  (flit_c[s+1]),
        .count_o     (count_c[s])
      );
    end

    always_comb begin
      occ_sum = '0;
      for (int s = 0; s < LINK_STAGES; s++) begin
        occ_sum = occ_sum + OCC_W'(count_c[s]);
      end
    end
    assign occupancy = occ_sum;

    // Credit-style VC ready travels upstream with the same depth as the flits travel downstream.
    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
      if (!noc_rst_n) begin
        for (int s = 0; s < LINK_STAGES; s++) begin
          vc_q[s] <= '0;
        end
      end else begin
        vc_q[0] <= tx_vc_ready;
        for (int s = 1; s < LINK_STAGES; s++) begin
          vc_q[s] <= vc_q[s-1];
        end
      end
    end
    assign rx_vc_ready = vc_q[LINK_STAGES-1];
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (tx_valid && tx_ready && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign flit_cnt = cnt_q;

endmodule
